// File: rtl/id_ex_reg_pkg.sv
// Shared constants and encodings for the ID/EX pipeline register of the MIPS core.
// Holds the widths, control-field encodings and the all-zero bubble control word.
package id_ex_reg_pkg;

  localparam int ALUOP_W = 4;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;

  // Destination register select carried in RegDst.
  typedef enum logic [1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'd0,
    MEMTOREG_MEM = 2'd1,
    MEMTOREG_PC4 = 2'd2
  } memtoreg_e;

  typedef enum logic [1:0] {
    EXTOP_ZERO = 2'd0,
    EXTOP_SIGN = 2'd1,
    EXTOP_HIGH = 2'd2
  } extop_e;

  // ALUOp + ALUSrc + RegDst(2) + MemRead + MemWrite + RegWrite + MemtoReg(2) + valid
  localparam int CTRL_W = ALUOP_W + 9;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-side and execute-side signal bundle of the ID/EX register.
// The master drives the decode fields; the slave (the register) drives the execute fields.
interface id_ex_reg_if
  import id_ex_reg_pkg::*;
#(
  parameter int ALUOP_W = id_ex_reg_pkg::ALUOP_W
) ();

  logic [DATA_W-1:0]  PC4_D, RD1_D, RD2_D, Imm32_D;
  logic [REG_W-1:0]   Rs_D, Rt_D, Rd_D, Shamt_D;
  logic [ALUOP_W-1:0] ALUOp_D;
  logic               ALUSrc_D;
  logic [1:0]         RegDst_D;
  logic               MemRead_D, MemWrite_D, RegWrite_D;
  logic [1:0]         MemtoReg_D;
  logic               valid_D;

  logic [DATA_W-1:0]  PC4_E, RD1_E, RD2_E, Imm32_E;
  logic [REG_W-1:0]   Rs_E, Rt_E, Rd_E, Shamt_E;
  logic [ALUOP_W-1:0] ALUOp_E;
  logic               ALUSrc_E;
  logic [1:0]         RegDst_E;
  logic               MemRead_E, MemWrite_E, RegWrite_E;
  logic [1:0]         MemtoReg_E;
  logic               valid_E;

  logic               ld_use_hazard;

  modport master (
    output PC4_D, RD1_D, RD2_D, Imm32_D, Rs_D, Rt_D, Rd_D, Shamt_D,
           ALUOp_D, ALUSrc_D, RegDst_D, MemRead_D, MemWrite_D, RegWrite_D,
           MemtoReg_D, valid_D,
    input  PC4_E, RD1_E, RD2_E, Imm32_E, Rs_E, Rt_E, Rd_E, Shamt_E,
           ALUOp_E, ALUSrc_E, RegDst_E, MemRead_E, MemWrite_E, RegWrite_E,
           MemtoReg_E, valid_E, ld_use_hazard
  );

  modport slave (
    input  PC4_D, RD1_D, RD2_D, Imm32_D, Rs_D, Rt_D, Rd_D, Shamt_D,
           ALUOp_D, ALUSrc_D, RegDst_D, MemRead_D, MemWrite_D, RegWrite_D,
           MemtoReg_D, valid_D,
    output PC4_E, RD1_E, RD2_E, Imm32_E, Rs_E, Rt_E, Rd_E, Shamt_E,
           ALUOp_E, ALUSrc_E, RegDst_E, MemRead_E, MemWrite_E, RegWrite_E,
           MemtoReg_E, valid_E, ld_use_hazard
  );

endinterface

// File: rtl/id_ex_reg_flopenrc.sv
// Parameterised-width flop with load enable, synchronous clear and synchronous reset.
// Priority: rst (to zero), then clr (to CLR_VAL), then en (load d), else hold.
module flopenrc #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode values for execute, with stall, flush and
// a valid bit, and flags a load-use hazard against the instruction now in decode.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int ALUOP_W = id_ex_reg_pkg::ALUOP_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  id_ex_reg_if.slave bus
);

  localparam int DATA_GRP_W = 4 * DATA_W;
  localparam int SPEC_GRP_W = 4 * REG_W;
  localparam int CTRL_GRP_W = ALUOP_W + 9;
  localparam logic [CTRL_GRP_W-1:0] CTRL_CLR = CTRL_GRP_W'(BUBBLE_CTRL);

  logic [DATA_GRP_W-1:0] data_d, data_q;
  logic [SPEC_GRP_W-1:0] spec_d, spec_q;
  logic [CTRL_GRP_W-1:0] ctrl_d, ctrl_q;

  always_comb begin
    data_d = {bus.PC4_D, bus.RD1_D, bus.RD2_D, bus.Imm32_D};
    spec_d = {bus.Rs_D, bus.Rt_D, bus.Rd_D, bus.Shamt_D};
    ctrl_d = {bus.ALUOp_D, bus.ALUSrc_D, bus.RegDst_D, bus.MemRead_D,
              bus.MemWrite_D, bus.RegWrite_D, bus.MemtoReg_D, bus.valid_D};
  end

  // ---- ID -> EX boundary: flush wins over a deasserted enable ----
  flopenrc #(.WIDTH(DATA_GRP_W), .CLR_VAL('0)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  flopenrc #(.WIDTH(SPEC_GRP_W), .CLR_VAL('0)) u_spec (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (flush),
    .d   (spec_d),
    .q   (spec_q)
  );

  flopenrc #(.WIDTH(CTRL_GRP_W), .CLR_VAL(CTRL_CLR)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  assign {bus.PC4_E, bus.RD1_E, bus.RD2_E, bus.Imm32_E} = data_q;
  assign {bus.Rs_E, bus.Rt_E, bus.Rd_E, bus.Shamt_E}     = spec_q;
  assign {bus.ALUOp_E, bus.ALUSrc_E, bus.RegDst_E, bus.MemRead_E,
          bus.MemWrite_E, bus.RegWrite_E, bus.MemtoReg_E, bus.valid_E} = ctrl_q;

  // A load in execute whose target ($0 excluded) is a source of the decode instruction.
  assign bus.ld_use_hazard = bus.valid_E & bus.MemRead_E & (bus.Rt_E != '0) &
                             ((bus.Rt_E == bus.Rs_D) | (bus.Rt_E == bus.Rt_D));

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and randomized bench for id_ex_reg against a slot-level reference model.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  typedef struct packed {
    logic [31:0]        pc4, rd1, rd2, imm;
    logic [4:0]         rs, rt, rd, shamt;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic [1:0]         regdst;
    logic               memread, memwrite, regwrite;
    logic [1:0]         memtoreg;
    logic               valid;
  } slot_t;

  localparam int SW = $bits(slot_t);

  logic clk = 1'b0;
  logic rst, en, flush;
  slot_t cur_d, model, pre, dep;
  int compared = 0;
  int mismatched = 0;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic apply();
    bus.PC4_D      = cur_d.pc4;
    bus.RD1_D      = cur_d.rd1;
    bus.RD2_D      = cur_d.rd2;
    bus.Imm32_D    = cur_d.imm;
    bus.Rs_D       = cur_d.rs;
    bus.Rt_D       = cur_d.rt;
    bus.Rd_D       = cur_d.rd;
    bus.Shamt_D    = cur_d.shamt;
    bus.ALUOp_D    = cur_d.aluop;
    bus.ALUSrc_D   = cur_d.alusrc;
    bus.RegDst_D   = cur_d.regdst;
    bus.MemRead_D  = cur_d.memread;
    bus.MemWrite_D = cur_d.memwrite;
    bus.RegWrite_D = cur_d.regwrite;
    bus.MemtoReg_D = cur_d.memtoreg;
    bus.valid_D    = cur_d.valid;
  endtask

  function automatic slot_t get_e();
    slot_t s;
    s.pc4 = bus.PC4_E;       s.rd1 = bus.RD1_E;       s.rd2 = bus.RD2_E;
    s.imm = bus.Imm32_E;     s.rs = bus.Rs_E;         s.rt = bus.Rt_E;
    s.rd = bus.Rd_E;         s.shamt = bus.Shamt_E;   s.aluop = bus.ALUOp_E;
    s.alusrc = bus.ALUSrc_E; s.regdst = bus.RegDst_E; s.memread = bus.MemRead_E;
    s.memwrite = bus.MemWrite_E; s.regwrite = bus.RegWrite_E;
    s.memtoreg = bus.MemtoReg_E; s.valid = bus.valid_E;
    return s;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.pc4 = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    s.rs = 5'($urandom_range(0, 3));  s.rt = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom); s.shamt = 5'($urandom); s.aluop = ALUOP_W'($urandom);
    s.alusrc = 1'($urandom); s.regdst = 2'($urandom_range(0, 2));
    s.memread = 1'($urandom); s.memwrite = 1'($urandom); s.regwrite = 1'($urandom);
    s.memtoreg = 2'($urandom_range(0, 2)); s.valid = 1'($urandom);
    return s;
  endfunction

  // Execute slot after one edge: reset or flush leave a bubble, a stall keeps the slot.
  function automatic slot_t model_next();
    if (rst || flush) return '0;
    if (!en) return model;
    return cur_d;
  endfunction

  function automatic logic hz_model();
    return model.valid && model.memread && (model.rt != 5'd0) &&
           ((model.rt == cur_d.rs) || (model.rt == cur_d.rt));
  endfunction

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk(tag, get_e(), model);
  endtask

  task automatic chk_hz(input string tag);
    chk(tag, SW'(bus.ld_use_hazard), SW'(hz_model()));
  endtask

  task automatic tick();
    slot_t nxt;
    apply();
    nxt = model_next();
    @(posedge clk);
    model = nxt;
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0;
    model = '0;

    // Reset with enable high and every decode field nonzero
    cur_d = rand_slot();
    cur_d.rs = 5'd7; cur_d.rt = 5'd3; cur_d.valid = 1'b1; cur_d.memread = 1'b1;
    cur_d.regwrite = 1'b1; cur_d.memwrite = 1'b1; cur_d.alusrc = 1'b1;
    cur_d.pc4 = cur_d.pc4 | 32'h1;
    rst = 1'b1; en = 1'b1;
    tick();
    chk("reset_all_zero", get_e(), '0);
    chk("reset_valid", SW'(bus.valid_E), SW'(1'b0));
    chk_hz("reset_hazard");
    rst = 1'b0;

    // Plain load
    cur_d = rand_slot();
    cur_d.imm = 32'hFFFF8000; cur_d.rd1 = 32'h12345678;
    cur_d.alusrc = 1'b1; cur_d.valid = 1'b1; cur_d.regwrite = 1'b1;
    cur_d.memwrite = 1'b1;
    pre = cur_d;
    tick();
    chk("load_imm", SW'(bus.Imm32_E), SW'(32'hFFFF8000));
    chk("load_rd1", SW'(bus.RD1_E), SW'(32'h12345678));
    chk("load_alusrc", SW'(bus.ALUSrc_E), SW'(1'b1));
    chk("load_valid", SW'(bus.valid_E), SW'(1'b1));
    chk("load_full", get_e(), pre);

    // Stall for three cycles while the decode side keeps changing
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_d = rand_slot();
      tick();
      chk("hold_full", get_e(), pre);
    end

    // Flush beats a deasserted enable
    flush = 1'b1; en = 1'b0;
    cur_d = rand_slot(); cur_d.regwrite = 1'b1; cur_d.valid = 1'b1;
    tick();
    chk("flush_regwrite", SW'(bus.RegWrite_E), SW'(1'b0));
    chk("flush_memwrite", SW'(bus.MemWrite_E), SW'(1'b0));
    chk("flush_valid", SW'(bus.valid_E), SW'(1'b0));
    chk_state("flush_full");
    flush = 1'b0;

    // Load-use detection against a held lw with rt = 8
    en = 1'b1;
    cur_d = rand_slot();
    cur_d.rt = 5'd8; cur_d.memread = 1'b1; cur_d.valid = 1'b1;
    tick();
    en = 1'b0;
    cur_d.rs = 5'd8; cur_d.rt = 5'd1; apply(); #1;
    chk("lu_rs_match", SW'(bus.ld_use_hazard), SW'(1'b1));
    cur_d.rs = 5'd2; cur_d.rt = 5'd8; apply(); #1;
    chk("lu_rt_match", SW'(bus.ld_use_hazard), SW'(1'b1));
    cur_d.rs = 5'd9; cur_d.rt = 5'd10; apply(); #1;
    chk("lu_no_match", SW'(bus.ld_use_hazard), SW'(1'b0));

    // A load targeting $0 never raises the hazard
    en = 1'b1;
    cur_d = rand_slot();
    cur_d.rt = 5'd0; cur_d.memread = 1'b1; cur_d.valid = 1'b1;
    tick();
    cur_d.rs = 5'd0; cur_d.rt = 5'd0; apply(); #1;
    chk("lu_reg_zero", SW'(bus.ld_use_hazard), SW'(1'b0));

    // Stall sequence: lw r5, then a dependent instruction reading r5
    cur_d = rand_slot();
    cur_d.rt = 5'd5; cur_d.memread = 1'b1; cur_d.valid = 1'b1;
    tick();
    dep = rand_slot();
    dep.rs = 5'd5; dep.rt = 5'd6; dep.imm = 32'h0000ABCD; dep.valid = 1'b1;
    dep.memread = 1'b0;
    cur_d = dep; apply(); #1;
    chk("stall_hazard", SW'(bus.ld_use_hazard), SW'(1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall_bubble_valid", SW'(bus.valid_E), SW'(1'b0));
    chk("stall_bubble_full", get_e(), '0);
    chk("stall_bubble_nohz", SW'(bus.ld_use_hazard), SW'(1'b0));
    tick();
    chk("stall_dep_imm", SW'(bus.Imm32_E), SW'(32'h0000ABCD));
    chk("stall_dep_rs", SW'(bus.Rs_E), SW'(5'd5));
    chk("stall_dep_full", get_e(), dep);

    // Randomized traffic with occasional reset, flush and stall
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      cur_d = rand_slot();
      tick();
      chk_state("rand_state");
      chk_hz("rand_hazard");
      cur_d.rs = 5'($urandom_range(0, 3));
      cur_d.rt = 5'($urandom_range(0, 3));
      apply(); #1;
      chk_hz("rand_hazard_dchg");
    end
    rst = 1'b0; flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It captures the decode-stage datapath values at each clock edge and hands them to the execute stage one cycle later. Those values are the extended 32-bit immediate from the immediate extender, the register-file read data, the register specifiers and the decoded control bits. It supports stall (hold), flush (bubble insertion) and a valid bit, and reports the load-use hazard between the instruction it holds and the one currently in decode.

## Interface
- `ALUOP_W`, default 4: width of the ALU operation code; the value comes from `ctrl_def.v`.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: load enable; 0 holds all registers.
- `flush` in 1: replaces the next captured instruction with a bubble.
- `PC4_D` in 32: PC+4 of the decode instruction.
- `RD1_D`, `RD2_D` in 32 each: register-file read data for rs and rt.
- `Imm32_D` in 32: output of the immediate extender (zero-, sign- or high-extended).
- `Rs_D`, `Rt_D`, `Rd_D`, `Shamt_D` in 5 each: instruction fields.
- `ALUOp_D` in `ALUOP_W`: ALU operation code.
- `ALUSrc_D` in 1: selects the ALU B operand (1 = immediate).
- `RegDst_D` in 2: selects the destination register (rt, rd or $31).
- `MemRead_D`, `MemWrite_D`, `RegWrite_D` in 1 each: memory and register-file write controls.
- `MemtoReg_D` in 2: write-back source select.
- `valid_D` in 1: decode slot holds a real instruction.
- `*_E` out, same widths as the matching `*_D` inputs: registered copies of every input above.
- `valid_E` out 1: execute slot holds a real instruction.
- `ld_use_hazard` out 1: combinational load-use stall request.

## Operation
- Priority on each rising `clk`, highest first: `rst`, then `flush`, then `en` = 0, then load.
- **Reset** (`rst` = 1): every `*_E` output goes to 0 and `valid_E` to 0; this holds regardless of `en` or `flush`.
- **Flush** (`flush` = 1): inserts a bubble. Every `*_E` output goes to 0, so RegWrite, MemWrite and MemRead are 0 and `valid_E` is 0. Flush is applied even when `en` = 0.
- **Hold** (`en` = 0, `flush` = 0): all registers keep their values.
- **Load** (`en` = 1): every `*_E` output takes the matching `*_D` input, including `valid_E` from `valid_D`.
- Registers hold two states per slot, VALID (`valid_E` = 1) and BUBBLE (`valid_E` = 0):
  - BUBBLE to VALID on a load with `valid_D` = 1.
  - VALID to BUBBLE on `flush`, on `rst`, or on a load with `valid_D` = 0.
- **Hazard output**: `ld_use_hazard` = `valid_E` & `MemRead_E` & (`Rt_E` ≠ 0) & ((`Rt_E` == `Rs_D`) | (`Rt_E` == `Rt_D`)).
  - The hazard unit uses it to drive `en` low on IF/ID and `flush` high on this block.
  - Register $0 never raises a hazard.
- The immediate is stored unmodified; this block performs no extension or width change. All fields keep the widths listed under Interface.

## Timing
- Latency from any `*_D` input to the matching `*_E` output: 1 cycle.
- `ld_use_hazard` is purely combinational from the registered `*_E` state and the `Rs_D`/`Rt_D` inputs; there is no extra cycle.
- A hazard asserted in cycle N, fed back as `flush`, leaves a bubble in execute during cycle N+1. The stalled decode instruction loads at edge N+1.
- `flush` and `en` are sampled only at the clock edge. Glitches between edges have no effect.
- Reset asserted mid-stream discards the held instruction within 1 cycle. After `rst` deasserts, the first load occurs at the next edge with `en` = 1.

## Structure
- `ctrl_def.v` holds the shared constants, alongside the existing `EXTOP_*` codes:
  - `ALUOP_W`;
  - the `REGDST_*` and `MEMTOREG_*` encodings;
  - `BUBBLE_CTRL`, the all-zero control word.
- Sub-module `flopenrc`: a parameterised-width flop with enable, synchronous clear and synchronous reset. Instantiate it once per field group (data, specifiers, control).
- The hazard comparator stays inline in this block.

## Test plan
- **Reset**: pulse `rst` with `en` = 1 and all `*_D` inputs nonzero. Next cycle every `*_E` output is 0 and `valid_E` = 0.
- **Load**: `en` = 1, `Imm32_D` = 0xFFFF8000, `RD1_D` = 0x12345678, `ALUSrc_D` = 1, `valid_D` = 1. One cycle later `Imm32_E` = 0xFFFF8000, `RD1_E` = 0x12345678, `ALUSrc_E` = 1, `valid_E` = 1.
- **Hold**: hold `en` = 0 for 3 cycles while the inputs change every cycle. All `*_E` outputs stay at their pre-stall values.
- **Flush priority**: `flush` = 1 and `en` = 0 with `RegWrite_D` = 1. Next cycle `RegWrite_E` = 0, `MemWrite_E` = 0 and `valid_E` = 0.
- **Load-use**: hold lw with `Rt_E` = 8, `MemRead_E` = 1, `valid_E` = 1, and apply `Rs_D` = 8. `ld_use_hazard` = 1; with `Rs_D` = 9 and `Rt_D` = 10 it is 0. With `Rt_E` = 0 and `Rs_D` = 0 it is 0.
- **Stall sequence**: hazard asserted, then `flush` = 1 for one cycle. Execute shows a bubble for exactly 1 cycle, then the dependent instruction appears with the correct `Imm32_E` and `Rs_E`.
